// File: rtl/forthsuper_pkg.sv
// rtl/forthsuper_pkg.sv - shared ForthSuper types: stack op encoding and stack size defaults.
package forthsuper_pkg;

  typedef enum logic [1:0] {
    SS_PICK = 2'd0,
    SS_PUSH = 2'd1,
    SS_POP  = 2'd2,
    SS_LOAD = 2'd3
  } sop_e;

  localparam int DEPTH_DEF = 64;
  localparam int DSZ_DEF   = 32;

endpackage

// File: rtl/ss_ram.sv
// rtl/ss_ram.sv - stack spill RAM: DEPTH x DSZ, asynchronous read, synchronous write.
module ss_ram #(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [DSZ-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [DSZ-1:0] rdata
);

  logic [DSZ-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reads see the contents before this cycle's write lands.
  assign rdata = mem[raddr];

endmodule

// File: rtl/modport_stack.sv
// rtl/modport_stack.sv - ForthSuper data stack engine (tos/s0 registers, RAM spill).
// Define SS_GUARD_EN to block overflow/underflow and expose ovf/udf pulses.
module modport_stack
  import forthsuper_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DSZ   = DSZ_DEF,
  localparam int SSZ  = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  sop_e           op,
  input  logic [DSZ-1:0] vi,
  output logic [SSZ-1:0] sp,
  output logic [DSZ-1:0] s0,
  output logic [DSZ-1:0] tos
`ifdef SS_GUARD_EN
  ,
  output logic           ovf,
  output logic           udf
`endif
);

  logic [SSZ-1:0] sp_up;
  logic [SSZ-1:0] sp_dn;
  logic [SSZ-1:0] pick_n;
  logic [SSZ-1:0] raddr;
  logic [DSZ-1:0] rdata;
  logic           push_ok;
  logic           pop_ok;
  logic           we;

  assign sp_up  = sp + 1'b1;
  assign sp_dn  = sp - 1'b1;
  assign pick_n = vi[SSZ-1:0];
  assign raddr  = (op == SS_POP) ? sp_dn : (sp - pick_n);

`ifdef SS_GUARD_EN
  assign push_ok = (sp != {SSZ{1'b1}});
  assign pop_ok  = (sp != '0);
`else
  assign push_ok = 1'b1;
  assign pop_ok  = 1'b1;
`endif

  assign we = !rst && en && (op == SS_PUSH) && push_ok;

  ss_ram #(.DEPTH(DEPTH), .DSZ(DSZ)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (sp_up),
    .wdata (tos),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tos <= '1;
      s0  <= '0;
      sp  <= '0;
    end else if (en) begin
      case (op)
        SS_PUSH: if (push_ok) begin
          s0  <= tos;
          sp  <= sp_up;
          tos <= vi;
        end
        SS_POP: if (pop_ok) begin
          tos <= s0;
          s0  <= rdata;
          sp  <= sp_dn;
        end
        SS_LOAD: tos <= vi;
        SS_PICK: tos <= (pick_n == '0) ? s0 : rdata;
        default: ;
      endcase
    end
  end

`ifdef SS_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= en && (op == SS_PUSH) && !push_ok;
      udf <= en && (op == SS_POP) && !pop_ok;
    end
  end
`endif

endmodule

// File: tb/tb_modport_stack.sv
// tb/tb_modport_stack.sv - randomized self-checking bench for modport_stack against a slot-array model.
module tb_modport_stack;
  import forthsuper_pkg::*;

  localparam int DEPTH = 64;
  localparam int DSZ   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  sop_e        op  = SS_PICK;
  logic [31:0] vi  = '0;
  logic [5:0]  sp;
  logic [31:0] s0;
  logic [31:0] tos;
`ifdef SS_GUARD_EN
  logic        ovf;
  logic        udf;
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  modport_stack #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .op  (op),
    .vi  (vi),
    .sp  (sp),
    .s0  (s0),
    .tos (tos)
`ifdef SS_GUARD_EN
    ,
    .ovf (ovf),
    .udf (udf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: stack slots as a plain array with a "has been written" flag.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_tos, m_s0;
  bit          m_tos_k, m_s0_k;
  int          m_sp;
  bit          m_ovf, m_udf;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_apply(input bit e, input sop_e o, input logic [31:0] v, input bit r);
    int n, a;
    if (r) begin
      m_tos = 32'hFFFF_FFFF; m_s0 = 0; m_sp = 0;
      m_tos_k = 1; m_s0_k = 1; m_ovf = 0; m_udf = 0;
      return;
    end
    m_ovf = 0; m_udf = 0;
    if (!e) return;
    case (o)
      SS_PUSH: begin
        if (GUARD && m_sp == DEPTH - 1) m_ovf = 1;
        else begin
          a = (m_sp + 1) % DEPTH;
          m_mem[a] = m_tos; m_known[a] = m_tos_k;
          m_s0 = m_tos; m_s0_k = m_tos_k;
          m_sp = a;
          m_tos = v; m_tos_k = 1;
        end
      end
      SS_POP: begin
        if (GUARD && m_sp == 0) m_udf = 1;
        else begin
          a = (m_sp + DEPTH - 1) % DEPTH;
          m_tos = m_s0; m_tos_k = m_s0_k;
          m_s0 = m_mem[a]; m_s0_k = m_known[a];
          m_sp = a;
        end
      end
      SS_LOAD: begin
        m_tos = v; m_tos_k = 1;
      end
      default: begin
        n = int'(v % DEPTH);
        if (n == 0) begin
          m_tos = m_s0; m_tos_k = m_s0_k;
        end else begin
          a = (m_sp + DEPTH - n) % DEPTH;
          m_tos = m_mem[a]; m_tos_k = m_known[a];
        end
      end
    endcase
  endtask

  task automatic step(input bit e, input sop_e o, input logic [31:0] v, input bit r);
    en = e; op = o; vi = v; rst = r;
    @(posedge clk);
    #1;
    model_apply(e, o, v, r);
    check("sp", {26'd0, sp}, m_sp[31:0]);
    if (m_tos_k) check("tos", tos, m_tos);
    if (m_s0_k)  check("s0", s0, m_s0);
`ifdef SS_GUARD_EN
    check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    check("udf", {31'd0, udf}, {31'd0, m_udf});
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_known[i] = 0;
      m_mem[i] = '0;
    end

    // Reset and hold
    step(0, SS_PICK, 0, 1);
    check("rst_tos", tos, 32'hFFFF_FFFF);
    check("rst_s0", s0, 32'h0);
    check("rst_sp", {26'd0, sp}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, SS_PUSH, 32'hDEAD_0000 + i, 0);
    check("hold_tos", tos, 32'hFFFF_FFFF);

    // Push / pop
    step(1, SS_PUSH, 5, 0);
    step(1, SS_PUSH, 7, 0);
    step(1, SS_PUSH, 9, 0);
    check("p3_tos", tos, 32'd9);
    check("p3_s0", s0, 32'd7);
    check("p3_sp", {26'd0, sp}, 32'd3);
    step(1, SS_POP, 0, 0);
    step(1, SS_POP, 0, 0);
    check("pp_tos", tos, 32'd5);
    check("pp_s0", s0, 32'hFFFF_FFFF);
    check("pp_sp", {26'd0, sp}, 32'd1);

    // Load and pick on 5/7/9
    step(1, SS_PUSH, 7, 0);
    step(1, SS_PUSH, 9, 0);
    step(1, SS_LOAD, 32'h1234, 0);
    check("ld_tos", tos, 32'h1234);
    check("ld_s0", s0, 32'd7);
    step(1, SS_PICK, 0, 0);
    check("pick0", tos, 32'd7);
    step(1, SS_LOAD, 9, 0);
    step(1, SS_PICK, 32'hFFFF_FF01, 0);
    check("pick1_hibits", tos, 32'd5);
    step(1, SS_LOAD, 9, 0);
    step(1, SS_PICK, 2, 0);
    check("pick_sp", {26'd0, sp}, 32'd3);

    // Reset wins over a same-cycle op
    step(1, SS_PUSH, 1, 0);
    step(1, SS_POP, 0, 0);
    step(1, SS_LOAD, 32'hCAFE_F00D, 1);
    check("rw_tos", tos, 32'hFFFF_FFFF);
    check("rw_s0", s0, 32'h0);
    check("rw_sp", {26'd0, sp}, 32'd0);

    // Fill from reset
    step(0, SS_PICK, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, SS_PUSH, 32'h100 + i, 0);
`ifdef SS_GUARD_EN
    check("full_sp", {26'd0, sp}, 32'd63);
    check("full_ovf", {31'd0, ovf}, 32'd1);
    step(0, SS_PICK, 0, 0);
    check("ovf_pulse", {31'd0, ovf}, 32'd0);
    step(0, SS_PICK, 0, 1);
    step(1, SS_POP, 0, 0);
    check("empty_udf", {31'd0, udf}, 32'd1);
    check("empty_sp", {26'd0, sp}, 32'd0);
`else
    check("wrap_sp", {26'd0, sp}, 32'd0);
    check("wrap_tos", tos, 32'h13F);
`endif

    // Randomized mix, biased toward stack traffic
    for (int i = 0; i < 600; i++) begin
      bit   r_e, r_r;
      sop_e r_o;
      logic [31:0] r_v;
      r_e = ($urandom_range(0, 9) != 0);
      r_r = ($urandom_range(0, 79) == 0);
      r_o = sop_e'($urandom_range(0, 3));
      r_v = $urandom;
      if (r_o == SS_PICK && $urandom_range(0, 1) == 1)
        r_v = {$urandom_range(0, 3), 24'd0, 2'd0, 6'($urandom_range(0, 4))};
      step(r_e, r_o, r_v, r_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
